// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 configuration path:
// table markers, device id, controller state encoding.
package cam_pkg;

   localparam logic [15:0] ENTRY_END = 16'hFFFF;
   localparam logic [15:0] ENTRY_DLY = 16'hFFF0;
   localparam logic [7:0]  OV7670_ID = 8'h42;

   typedef enum logic [2:0] {
      PWRUP,
      LOAD,
      START,
      BIT,
      STOP,
      GAP,
      WAIT,
      DONE
   } sccb_state_t;

   // Slots 9, 18, 27 (0-based 8, 17, 26) carry the ignored ACK bit
   function automatic logic is_dc_slot(input logic [4:0] s);
      return (s == 5'd8) || (s == 5'd17) || (s == 5'd26);
   endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// OV7670 register table, RGB565 / QVGA.
// idx: table index in; entry: {reg_addr, reg_data} out.
module ov7670_reg_rom
   import cam_pkg::*;
(
   input  logic [7:0]  idx,
   output logic [15:0] entry
);

   always_comb begin
      entry = ENTRY_END;
      unique case (idx)
         8'd0:    entry = 16'h1280;
         8'd1:    entry = ENTRY_DLY;
         8'd2:    entry = 16'h1204;
         8'd3:    entry = 16'h40D0;
         8'd4:    entry = 16'h1100;
         8'd5:    entry = 16'h0C04;
         8'd6:    entry = 16'h3E19;
         8'd7:    entry = 16'h7211;
         8'd8:    entry = 16'h73F1;
         8'd9:    entry = 16'h8C00;
         8'd10:   entry = 16'h3A04;
         default: entry = ENTRY_END;
      endcase
   end

endmodule

// File: rtl/sccb_config_ctrl.sv
// OV7670 power-up sequencer: walks the register table and issues
// SCCB 3-phase writes; drives camera reset/pwdn, busy/done, wr_count.
module sccb_config_ctrl
   import cam_pkg::*;
#(
   parameter int          CLK_HZ  = 100_000_000,
   parameter int          SCCB_HZ = 100_000,
   parameter logic [7:0]  DEV_ID  = OV7670_ID,
   parameter int          DLY_CYC = 1_000_000
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       sioc,
   output logic       siod_o,
   output logic       siod_oe,
   output logic       cam_rst_n,
   output logic       cam_pwdn,
   output logic       busy,
   output logic       done,
   output logic [7:0] wr_count
);

   localparam int QTR = CLK_HZ / (4 * SCCB_HZ);
   localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;
   localparam int DW  = $clog2(DLY_CYC + 1);

   sccb_state_t state_q, state_d;
   logic [QW-1:0] div_q, div_d;
   logic [1:0]    qtr_q, qtr_d;
   logic [4:0]    bit_q, bit_d;
   logic [23:0]   shift_q, shift_d;
   logic [DW-1:0] dly_q, dly_d;
   logic [7:0]    idx_q, idx_d;
   logic [7:0]    wr_q, wr_d;
   logic          sioc_q, sioc_d;
   logic          siod_q, siod_d;
   logic          oe_q, oe_d;
   logic          crst_q, crst_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [15:0]   entry;
   logic          tick;
   logic          dly_end;

   ov7670_reg_rom u_rom (
      .idx   (idx_q),
      .entry (entry)
   );

   assign tick    = (div_q == QW'(QTR - 1));
   assign dly_end = (dly_q == DW'(DLY_CYC - 1));

   always_comb begin
      state_d = state_q;
      div_d   = tick ? '0 : div_q + 1'b1;
      qtr_d   = qtr_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      dly_d   = dly_q;
      idx_d   = idx_q;
      wr_d    = wr_q;

      unique case (state_q)
         PWRUP: begin
            div_d = '0;
            if (dly_end) begin
               dly_d   = '0;
               state_d = LOAD;
            end else begin
               dly_d = dly_q + 1'b1;
            end
         end
         LOAD: begin
            div_d = '0;
            qtr_d = '0;
            if (entry == ENTRY_END) begin
               state_d = DONE;
            end else if (entry == ENTRY_DLY) begin
               dly_d   = '0;
               state_d = WAIT;
            end else begin
               shift_d = {DEV_ID, entry};
               state_d = START;
            end
         end
         START: begin
            if (tick) begin
               if (qtr_q == 2'd1) begin
                  qtr_d   = '0;
                  bit_d   = '0;
                  state_d = BIT;
               end else begin
                  qtr_d = qtr_q + 2'd1;
               end
            end
         end
         BIT: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3) begin
                  // ACK slots do not consume a data bit
                  if (!is_dc_slot(bit_q))
                     shift_d = {shift_q[22:0], 1'b0};
                  if (bit_q == 5'd26)
                     state_d = STOP;
                  else
                     bit_d = bit_q + 5'd1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (qtr_q == 2'd2) begin
                  qtr_d   = '0;
                  idx_d   = idx_q + 8'd1;
                  wr_d    = (wr_q == 8'hFF) ? wr_q : wr_q + 8'd1;
                  state_d = GAP;
               end else begin
                  qtr_d = qtr_q + 2'd1;
               end
            end
         end
         GAP: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3)
                  state_d = LOAD;
            end
         end
         WAIT: begin
            div_d = '0;
            if (dly_end) begin
               idx_d   = idx_q + 8'd1;
               state_d = LOAD;
            end else begin
               dly_d = dly_q + 1'b1;
            end
         end
         DONE: begin
            div_d = '0;
            if (start) begin
               idx_d   = '0;
               wr_d    = '0;
               state_d = LOAD;
            end
         end
      endcase
   end

   // Outputs are decoded from the next state so the registered
   // bus lines line up with the phase being entered.
   always_comb begin
      sioc_d = 1'b1;
      siod_d = 1'b1;
      oe_d   = 1'b1;
      crst_d = (state_d != PWRUP);
      busy_d = (state_d != DONE);
      done_d = (state_d == DONE);
      unique case (state_d)
         START: begin
            siod_d = 1'b0;
            sioc_d = (qtr_d == 2'd0);
         end
         BIT: begin
            sioc_d = qtr_d[1];
            if (is_dc_slot(bit_d))
               oe_d = 1'b0;
            else
               siod_d = shift_d[23];
         end
         STOP: begin
            sioc_d = (qtr_d != 2'd0);
            siod_d = (qtr_d == 2'd2);
         end
         default: begin
            sioc_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PWRUP;
         div_q   <= '0;
         qtr_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         dly_q   <= '0;
         idx_q   <= '0;
         wr_q    <= '0;
         sioc_q  <= 1'b1;
         siod_q  <= 1'b1;
         oe_q    <= 1'b1;
         crst_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         qtr_q   <= qtr_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         dly_q   <= dly_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         sioc_q  <= sioc_d;
         siod_q  <= siod_d;
         oe_q    <= oe_d;
         crst_q  <= crst_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign sioc      = sioc_q;
   assign siod_o    = siod_q;
   assign siod_oe   = oe_q;
   assign cam_rst_n = crst_q;
   assign cam_pwdn  = 1'b0;
   assign busy      = busy_q;
   assign done      = done_q;
   assign wr_count  = wr_q;

endmodule

// File: tb/tb_sccb_config_ctrl.sv
// Bench for sccb_config_ctrl: decodes the SCCB bus and checks it
// against a table-walking model of the configuration sequence.
module tb_sccb_config_ctrl;

   localparam int QTR     = 4;
   localparam int DLY_CYC = 50;
   localparam logic [7:0]  DEV_ID = 8'h42;
   localparam logic [15:0] E_END  = 16'hFFFF;
   localparam logic [15:0] E_DLY  = 16'hFFF0;
   localparam int TBL_N   = 12;
   localparam int BUDGET  = 3000;

   localparam logic [15:0] TBL [TBL_N] = '{
      16'h1280, 16'hFFF0, 16'h1204, 16'h40D0,
      16'h1100, 16'h0C04, 16'h3E19, 16'h7211,
      16'h73F1, 16'h8C00, 16'h3A04, 16'hFFFF
   };

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       sioc, siod_o, siod_oe;
   logic       cam_rst_n, cam_pwdn, busy, done;
   logic [7:0] wr_count;

   int cmp = 0;
   int errs = 0;
   logic [26:0] exp_oe;

   sccb_config_ctrl #(
      .CLK_HZ  (400),
      .SCCB_HZ (25),
      .DEV_ID  (DEV_ID),
      .DLY_CYC (DLY_CYC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .sioc      (sioc),
      .siod_o    (siod_o),
      .siod_oe   (siod_oe),
      .cam_rst_n (cam_rst_n),
      .cam_pwdn  (cam_pwdn),
      .busy      (busy),
      .done      (done),
      .wr_count  (wr_count)
   );

   always #5 clk = ~clk;

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Observes one transfer: waits for START (unless already there),
   // records the 27 bits and OE at each SIOC rise, ends at STOP.
   task automatic capture(input bit in_start,
                          output logic [26:0] bits,
                          output logic [26:0] oes,
                          output int oe0, output int gl,
                          output bit ok);
      int n, t;
      logic ps, pd;
      ok = 1; oe0 = 0; gl = 0; bits = '0; oes = '0; t = 0;
      if (!in_start) begin
         do begin
            pd = siod_o;
            @(negedge clk);
            t++;
         end while (!(sioc && !siod_o && pd) && t < BUDGET);
         if (t >= BUDGET) ok = 0;
      end
      n = 0;
      while (ok && n < 27) begin
         ps = sioc; pd = siod_o;
         @(negedge clk);
         t++;
         if (!siod_oe) oe0++;
         if (ps && sioc && siod_o !== pd) gl++;
         if (!ps && sioc) begin
            bits[26-n] = siod_o;
            oes[26-n]  = siod_oe;
            n++;
         end
         if (t > BUDGET) ok = 0;
      end
      if (ok) begin
         do begin
            pd = siod_o;
            @(negedge clk);
            t++;
            if (!siod_oe) oe0++;
         end while (!(sioc && siod_o && !pd) && t < 2 * BUDGET);
         if (t >= 2 * BUDGET) ok = 0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      cmp++; if ({sioc, siod_o, siod_oe} !== 3'b111) begin
         errs++; $display("FAIL rst_bus: got %b want 111",
                          {sioc, siod_o, siod_oe}); end
      cmp++; if ({cam_rst_n, cam_pwdn} !== 2'b00) begin
         errs++; $display("FAIL rst_cam: got %b want 00",
                          {cam_rst_n, cam_pwdn}); end
      cmp++; if ({busy, done} !== 2'b00) begin
         errs++; $display("FAIL rst_stat: got %b want 00",
                          {busy, done}); end
      cmp++; if (wr_count !== 8'd0) begin
         errs++; $display("FAIL rst_wr: got %0d want 0", wr_count); end
   endtask

   task automatic test_powerup();
      int low, bad, bbad, inj;
      low = 0; bad = 0; bbad = 0;
      inj = $urandom_range(5, 40);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         start = (t == inj);
         if (cam_rst_n) break;
         low++;
         if (!(sioc && siod_o && siod_oe)) bad++;
         if (t > 0 && !busy) bbad++;
      end
      start = 1'b0;
      cmp++; if (low !== DLY_CYC) begin
         errs++; $display("FAIL pwr_len: got %0d want %0d",
                          low, DLY_CYC); end
      cmp++; if (bad !== 0) begin
         errs++; $display("FAIL pwr_bus: got %0d want 0", bad); end
      cmp++; if (bbad !== 0 || busy !== 1'b1) begin
         errs++; $display("FAIL pwr_busy: got %0d/%b want 0/1",
                          bbad, busy); end
      cmp++; if (cam_pwdn !== 1'b0) begin
         errs++; $display("FAIL pwr_pwdn: got %b want 0", cam_pwdn); end
   endtask

   task automatic test_first_write();
      logic [26:0] bits, oes;
      int oe0, gl;
      bit ok;
      capture(1'b0, bits, oes, oe0, gl, ok);
      cmp++; if (ok !== 1'b1) begin
         errs++; $display("FAIL w0_done: got %b want 1", ok); return; end
      cmp++; if (bits[26:19] !== DEV_ID) begin
         errs++; $display("FAIL w0_id: got %h want %h",
                          bits[26:19], DEV_ID); end
      cmp++; if (bits[17:10] !== 8'h12) begin
         errs++; $display("FAIL w0_addr: got %h want 12",
                          bits[17:10]); end
      cmp++; if (bits[8:1] !== 8'h80) begin
         errs++; $display("FAIL w0_data: got %h want 80",
                          bits[8:1]); end
      cmp++; if (oes !== exp_oe) begin
         errs++; $display("FAIL w0_oe: got %b want %b", oes, exp_oe); end
      cmp++; if (oe0 !== 12 * QTR) begin
         errs++; $display("FAIL w0_oeclk: got %0d want %0d",
                          oe0, 12 * QTR); end
      cmp++; if (gl !== 0) begin
         errs++; $display("FAIL w0_hold: got %0d want 0", gl); end
   endtask

   task automatic test_delay();
      int run, exp_run, mid;
      exp_run = 5 * QTR + 2 + DLY_CYC;
      mid = 5 * QTR + 1 + DLY_CYC / 2;
      run = 1;
      for (int t = 0; t < exp_run + 100; t++) begin
         @(negedge clk);
         if (!(sioc && siod_o && siod_oe) || done) break;
         run++;
         if (run == mid) begin
            cmp++; if (wr_count !== 8'd1) begin
               errs++; $display("FAIL dly_wr: got %0d want 1",
                                wr_count); end
         end
      end
      cmp++; if (run !== exp_run) begin
         errs++; $display("FAIL dly_len: got %0d want %0d",
                          run, exp_run); end
      cmp++; if ({sioc, siod_o} !== 2'b10) begin
         errs++; $display("FAIL dly_start: got %b want 10",
                          {sioc, siod_o}); end
   endtask

   task automatic run_writes(input int first, input bit in_start);
      int idx, j, d, n, run, exp_run, inj, oe0, gl;
      logic [26:0] bits, oes;
      bit ok;
      idx = first; n = 0;
      for (int k = 0; k < first; k++)
         if (TBL[k] != E_DLY && TBL[k] != E_END) n++;
      while (idx < TBL_N && TBL[idx] != E_END) begin
         capture(in_start, bits, oes, oe0, gl, ok);
         cmp++; if (ok !== 1'b1) begin
            errs++; $display("FAIL wr_tmo: entry %0d got %b want 1",
                             idx, ok); return; end
         cmp++; if ({bits[26:19], bits[17:10], bits[8:1]}
                    !== {DEV_ID, TBL[idx]}) begin
            errs++; $display("FAIL wr_word: entry %0d got %h want %h",
               idx, {bits[26:19], bits[17:10], bits[8:1]},
               {DEV_ID, TBL[idx]}); end
         cmp++; if (oes !== exp_oe || oe0 !== 12 * QTR) begin
            errs++; $display("FAIL wr_oe: entry %0d got %b/%0d want %b/%0d",
               idx, oes, oe0, exp_oe, 12 * QTR); end
         cmp++; if (gl !== 0) begin
            errs++; $display("FAIL wr_hold: entry %0d got %0d want 0",
                             idx, gl); end
         n++;
         d = 0; j = idx + 1;
         while (TBL[j] == E_DLY) begin d++; j++; end
         exp_run = 5 * QTR + 1 + d * (DLY_CYC + 1);
         inj = $urandom_range(2, exp_run - 3);
         run = 1;
         for (int t = 0; t < exp_run + 100; t++) begin
            @(negedge clk);
            start = (run == inj);
            if (!(sioc && siod_o && siod_oe) || done) break;
            run++;
            if (run == 2 * QTR) begin
               cmp++; if (wr_count !== 8'(n)) begin
                  errs++; $display("FAIL gap_wr: got %0d want %0d",
                                   wr_count, n); end
            end
         end
         start = 1'b0;
         cmp++; if (run !== exp_run) begin
            errs++; $display("FAIL gap_len: entry %0d got %0d want %0d",
                             idx, run, exp_run); end
         if (TBL[j] == E_END) begin
            cmp++; if ({done, busy} !== 2'b10 || wr_count !== 8'(n)) begin
               errs++; $display("FAIL seq_end: got %b/%0d want 10/%0d",
                                {done, busy}, wr_count, n); end
         end else begin
            cmp++; if ({sioc, siod_o} !== 2'b10) begin
               errs++; $display("FAIL seq_next: got %b want 10",
                                {sioc, siod_o}); end
         end
         idx = j; in_start = 1'b1;
      end
   endtask

   task automatic test_restart();
      int w;
      w = $urandom_range(0, 10);
      repeat (w) @(negedge clk);
      cmp++; if (done !== 1'b1) begin
         errs++; $display("FAIL rs_hold: got %b want 1", done); end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cmp++; if ({done, busy, wr_count} !== {2'b01, 8'd0}) begin
         errs++; $display("FAIL rs_clear: got %b/%0d want 01/0",
                          {done, busy}, wr_count); end
      cmp++; if (cam_rst_n !== 1'b1) begin
         errs++; $display("FAIL rs_nopwr: got %b want 1", cam_rst_n); end
      @(negedge clk);
      cmp++; if ({sioc, siod_o} !== 2'b10) begin
         errs++; $display("FAIL rs_start: got %b want 10",
                          {sioc, siod_o}); end
      run_writes(0, 1'b1);
   endtask

   task automatic test_abort();
      int n, t, extra;
      logic ps, pd;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      do begin
         pd = siod_o; @(negedge clk); t++;
      end while (!(sioc && !siod_o && pd) && t < BUDGET);
      n = 0;
      while (n < 11 && t < BUDGET) begin
         ps = sioc; @(negedge clk); t++;
         if (!ps && sioc) n++;
      end
      while (sioc && t < BUDGET) begin @(negedge clk); t++; end
      cmp++; if (t >= BUDGET) begin
         errs++; $display("FAIL ab_reach: got %0d cycles want <%0d",
                          t, BUDGET); end
      extra = $urandom_range(0, 2 * QTR - 1);
      repeat (extra) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      cmp++; if ({sioc, siod_o, siod_oe} !== 3'b111) begin
         errs++; $display("FAIL ab_bus: got %b want 111",
                          {sioc, siod_o, siod_oe}); end
      cmp++; if ({cam_rst_n, busy, done, wr_count} !== 11'd0) begin
         errs++; $display("FAIL ab_stat: got %b/%0d want 000/0",
                          {cam_rst_n, busy, done}, wr_count); end
      repeat (3) @(negedge clk);
      test_powerup();
      run_writes(0, 1'b0);
   endtask

   initial begin
      for (int s = 0; s < 27; s++)
         exp_oe[26-s] = ((s % 9) != 8);
      test_reset();
      test_powerup();
      test_first_write();
      test_delay();
      run_writes(2, 1'b1);
      test_restart();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               cmp, errs);
      $finish;
   end

endmodule
